seq_div_32: RTL and testbench

SEQ_DIV_32 -- requirements
Module: seq_div_32

---
 rtl/seq_div_32.sv | 123 ++++++++++++
 tb/tb_seq_div_32.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_div_32.sv
// Signed 32-bit restoring divider: one quotient bit per cycle on operand magnitudes,
// with a sign fix-up cycle. Truncates toward zero; the remainder takes the dividend's sign.
module seq_div_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;    // 33-bit partial remainder
   logic [WIDTH-1:0] dvd_q, dvd_d;    // |dividend|, turns into |quotient| as bits shift in
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             qs_q, qs_d, rs_q, rs_d;
   logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
   logic             dbz_q, dbz_d, done_q, done_d;
   logic [WIDTH:0]   sh, diff;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         qs_q    <= 1'b0;
         rs_q    <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         qs_q    <= qs_d;
         rs_q    <= rs_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      qs_d    = qs_q;
      rs_d    = rs_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      // done is registered off the DONE state, so the pulse lands one cycle after it
      done_d  = (state_q == DONE);
      sh      = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      diff    = sh - {1'b0, dvs_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quo_d   = '1;
                  rmd_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  dvd_d   = dividend[WIDTH-1] ? -dividend : dividend;
                  dvs_d   = divisor[WIDTH-1]  ? -divisor  : divisor;
                  qs_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  rs_d    = dividend[WIDTH-1];
                  rem_d   = '0;
                  dbz_d   = 1'b0;
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (diff[WIDTH]) begin
               rem_d = sh;
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end else begin
               rem_d = diff;
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            quo_d   = qs_q ? -dvd_q : dvd_q;
            rmd_d   = rs_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign busy        = (state_q == RUN) || (state_q == FIX);
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_32.sv
// Directed bench for seq_div_32: hand-computed results, latency, busy length,
// start filtering and mid-operation reset.
module tb_seq_div_32;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [31:0] dividend, divisor, quotient, remainder;
   logic        busy, done, div_by_zero;

   int n_chk  = 0;
   int n_fail = 0;

   seq_div_32 dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch a divide, scramble operands while busy, and measure done latency / busy cycles.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
      dividend = a; divisor = b; start = 1'b1;
      tick();
      start = 1'b0; dividend = 32'h1234_5678; divisor = 32'h0000_0003;
      lat = 0; bcnt = 0;
      if (busy) bcnt++;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (busy) bcnt++;
         if (done) begin lat = k; break; end
      end
   endtask

   int lat, bcnt, ndone;

   initial begin
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      tick(); tick();
      chk("rst_quotient", quotient, 32'h0);
      chk("rst_remainder", remainder, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_dbz", {31'b0, div_by_zero}, 32'h0);
      rst_n = 1'b1;

      // 100 / 7, started on the first edge out of reset
      run_div(32'd100, 32'd7, lat, bcnt);
      chk("100/7 latency", lat, 32'd34);
      chk("100/7 busy_cycles", bcnt, 32'd33);
      chk("100/7 quotient", quotient, 32'h0000_000E);
      chk("100/7 remainder", remainder, 32'd2);
      chk("100/7 dbz", {31'b0, div_by_zero}, 32'h0);
      tick();
      chk("100/7 done_one_cycle", {31'b0, done}, 32'h0);
      chk("100/7 hold_quotient", quotient, 32'h0000_000E);

      run_div(-32'sd100, 32'd7, lat, bcnt);
      chk("-100/7 quotient", quotient, 32'hFFFF_FFF2);
      chk("-100/7 remainder", remainder, 32'hFFFF_FFFE);

      run_div(32'd100, -32'sd7, lat, bcnt);
      chk("100/-7 quotient", quotient, 32'hFFFF_FFF2);
      chk("100/-7 remainder", remainder, 32'd2);

      run_div(-32'sd7, -32'sd2, lat, bcnt);
      chk("-7/-2 quotient", quotient, 32'd3);
      chk("-7/-2 remainder", remainder, 32'hFFFF_FFFF);

      run_div(32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      chk("min/-1 quotient", quotient, 32'h8000_0000);
      chk("min/-1 remainder", remainder, 32'h0);
      chk("min/-1 dbz", {31'b0, div_by_zero}, 32'h0);

      run_div(32'h7FFF_FFFF, 32'd1, lat, bcnt);
      chk("max/1 quotient", quotient, 32'h7FFF_FFFF);
      chk("max/1 remainder", remainder, 32'h0);

      run_div(32'd0, -32'sd5, lat, bcnt);
      chk("0/-5 quotient", quotient, 32'h0);
      chk("0/-5 remainder", remainder, 32'h0);

      // 5 / 0 with a start held into the DONE cycle, which must be ignored
      dividend = 32'd5; divisor = 32'd0; start = 1'b1;
      tick();
      chk("5/0 busy_after_start", {31'b0, busy}, 32'h0);
      dividend = 32'd8; divisor = 32'd2;
      tick();
      start = 1'b0;
      chk("5/0 done_latency", {31'b0, done}, 32'h1);
      chk("5/0 busy", {31'b0, busy}, 32'h0);
      chk("5/0 quotient", quotient, 32'hFFFF_FFFF);
      chk("5/0 remainder", remainder, 32'd5);
      chk("5/0 dbz", {31'b0, div_by_zero}, 32'h1);
      tick();
      chk("start_in_done_ignored", {31'b0, busy}, 32'h0);
      chk("5/0 hold_dbz", {31'b0, div_by_zero}, 32'h1);

      // 1000 / 3 with a 9 / 9 start pulsed at RUN cycle 10
      dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      dividend = 32'd9; divisor = 32'd9; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      for (int k = 11; k <= 60; k++) begin
         tick();
         if (done) begin lat = k; break; end
      end
      chk("1000/3 ignore latency", lat, 32'd34);
      chk("1000/3 quotient", quotient, 32'd333);
      chk("1000/3 remainder", remainder, 32'd1);
      repeat (3) tick();
      chk("9/9 not executed", {31'b0, busy}, 32'h0);
      chk("9/9 not executed q", quotient, 32'd333);

      // 1000 / 3 abandoned by reset at RUN cycle 20
      dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst quotient", quotient, 32'h0);
      chk("midrst remainder", remainder, 32'h0);
      chk("midrst busy", {31'b0, busy}, 32'h0);
      chk("midrst done", {31'b0, done}, 32'h0);
      chk("midrst dbz", {31'b0, div_by_zero}, 32'h0);
      ndone = 0;
      repeat (40) begin
         tick();
         if (done) ndone++;
      end
      chk("midrst no_done", ndone, 32'd0);

      run_div(32'd6, 32'd4, lat, bcnt);
      chk("6/4 latency", lat, 32'd34);
      chk("6/4 quotient", quotient, 32'd1);
      chk("6/4 remainder", remainder, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
